// File: rtl/wb_sig_reader_pkg.sv
// Shared types for the Wishbone signature reader.
package wb_sig_reader_pkg;

  // Readout sequencer states, visible to benches for probing.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    EMPTY = 2'd3
  } rd_state_e;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_sig_reader_sync_fifo.sv
// Synchronous FIFO with registered storage; head is the oldest stored word.
module wb_sig_reader_sync_fifo
  import wb_sig_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           pop_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [cnt_width(DEPTH)-1:0]    count_o,
  output logic [DATA_WIDTH-1:0]          head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer/count update; a pop frees the slot a simultaneous push may take.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
    end
    if (do_pop) begin
      rd_ptr_d = PW'(rd_ptr_q + 1'b1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_sig_reader.sv
// Wishbone pipelined read initiator streaming a word-aligned region to a valid/ready port.
module wb_sig_reader
  import wb_sig_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   begin_addr_i,
  input  logic [ADDR_WIDTH-1:0]   end_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_stall_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic [DATA_WIDTH-1:0]   word_data_o,
  output logic                    word_last_o
);

  localparam int unsigned AW   = ADDR_WIDTH;
  localparam int unsigned SW   = DATA_WIDTH / 8;
  localparam int unsigned CW   = cnt_width(FIFO_DEPTH);
  localparam int unsigned SUMW = CW + 1;

  rd_state_e       state_q, state_d;
  logic [AW-1:0]   n_q, n_d;
  logic [AW-1:0]   issued_q, issued_d;
  logic [AW-1:0]   popped_q, popped_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [CW-1:0]   out_q, out_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [AW-1:0]   n_start;
  logic [CW-1:0]   cnt_d;
  logic            ack_v, accept, pop;
  logic            fifo_empty, fifo_full_unused;
  logic [CW-1:0]   fifo_count;

  // Acks with nothing outstanding (e.g. stale after reset) are dropped.
  assign ack_v  = wb_ack_i && (out_q != '0);
  assign accept = stb_q && !wb_stall_i;
  assign pop    = word_valid_o && word_ready_i;

  assign word_valid_o = !fifo_empty;
  assign word_last_o  = word_valid_o && (popped_q == n_q - AW'(1));

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = 1'b0;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = '0;

  wb_sig_reader_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ack_v),
    .data_i  (wb_dat_i),
    .pop_i   (pop),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (word_data_o)
  );

  // Next-state, counters and next-cycle bus outputs.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    issued_d = issued_q + AW'(accept);
    popped_d = popped_q + AW'(pop);
    adr_d    = accept ? adr_q + AW'(4) : adr_q;
    done_d   = 1'b0;
    sel_d    = '1;
    n_start  = (end_addr_i > begin_addr_i) ?
               ({2'b00, end_addr_i[AW-1:2]} - {2'b00, begin_addr_i[AW-1:2]}) : '0;

    case ({accept, ack_v})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d      = n_start;
          adr_d    = {begin_addr_i[AW-1:2], 2'b00};
          issued_d = '0;
          popped_d = '0;
          state_d  = (n_start != '0) ? READ : EMPTY;
        end
      end
      EMPTY: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        if ((issued_q == n_q) && (out_q == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && (popped_q == n_q)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Credit: requests in flight plus buffered words never exceed the FIFO depth.
    cnt_d  = fifo_count + CW'(ack_v) - CW'(pop);
    cyc_d  = (state_d == READ);
    busy_d = (state_d != IDLE);
    stb_d  = (state_d == READ) && (issued_d < n_d) &&
             ((SUMW'(out_d) + SUMW'(cnt_d)) < SUMW'(FIFO_DEPTH));
  end

  // State and output registers; reset drops cyc/stb immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      n_q      <= '0;
      issued_q <= '0;
      popped_q <= '0;
      adr_q    <= '0;
      out_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      adr_q    <= adr_d;
      out_q    <= out_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_wb_sig_reader.sv
// Directed bench for wb_sig_reader with a pipelined Wishbone memory model and stream sink.
module tb_wb_sig_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] beg_a, end_a;
  logic        busy, done;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdo;
  logic        ack, stall;
  logic [31:0] wdi;
  logic        valid, ready;
  logic [31:0] data;
  logic        last;

  always #5 clk = ~clk;

  wb_sig_reader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .begin_addr_i (beg_a),
    .end_addr_i   (end_a),
    .busy_o       (busy),
    .done_o       (done),
    .wb_cyc_o     (cyc),
    .wb_stb_o     (stb),
    .wb_we_o      (we),
    .wb_adr_o     (adr),
    .wb_sel_o     (sel),
    .wb_dat_o     (wdo),
    .wb_ack_i     (ack),
    .wb_stall_i   (stall),
    .wb_dat_i     (wdi),
    .word_valid_o (valid),
    .word_ready_i (ready),
    .word_data_o  (data),
    .word_last_o  (last)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: fixed words at 0x100, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;

  rsp_t        ack_q[$];
  logic [31:0] exp_q[$];
  int          cyc_n = 0;
  int          last_due = 0;
  int          stall_pct = 0;
  int          ack_max = 1;
  int          ready_mode = 0;  // 0 always ready, 1 held low, 2 random
  int          n_exp, rx_cnt, acc_cnt, model_out, max_out;
  int          done_cnt, done_cyc, start_cyc, cyc_seen, valid_seen, last_cnt;
  logic [31:0] next_adr;
  logic        hold_v;
  logic [31:0] hold_d;

  // Bus slave and stream sink: drive just after posedge, observe on negedge.
  initial begin
    rsp_t r;
    int   dl;
    ack = 1'b0; stall = 1'b0; wdi = '0; ready = 1'b1; hold_v = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc_n++;
      if (rst) begin
        ack_q.delete();
        ack = 1'b0;
        wdi = '0;
      end else if (ack_q.size() != 0 && ack_q[0].due <= cyc_n) begin
        r   = ack_q.pop_front();
        ack = 1'b1;
        wdi = r.d;
      end else begin
        ack = 1'b0;
        wdi = 32'hDEAD_BEEF;
      end
      stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(1));
      @(negedge clk);
      if (!rst) begin
        if (ack) begin
          check_val("ack_outstanding", 32'(model_out != 0), 32'd1);
          if (model_out > 0) model_out--;
        end
        if (stb && !stall) begin
          check_val("req_adr", adr, next_adr);
          check_val("req_sel_we", {27'd0, sel, we}, {27'd0, 4'hF, 1'b0});
          next_adr += 4;
          acc_cnt++;
          model_out++;
          dl    = cyc_n + int'($urandom_range(ack_max, 1));
          r.d   = mem_rd(adr);
          r.due = (dl > last_due) ? dl : last_due + 1;
          last_due = r.due;
          ack_q.push_back(r);
        end
        if (model_out > max_out) max_out = model_out;
        if (cyc) cyc_seen++;
        if (valid) valid_seen++;
        if (hold_v) begin
          check_val("hold_valid", 32'(valid), 32'd1);
          check_val("hold_data", data, hold_d);
        end
        hold_v = valid && !ready;
        hold_d = data;
        if (valid && ready) begin
          if (exp_q.size() != 0) check_val("word_data", data, exp_q.pop_front());
          else check_val("word_count", rx_cnt + 1, n_exp);
          check_val("word_last", 32'(last), 32'(rx_cnt == n_exp - 1));
          rx_cnt++;
          if (last) last_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc_n;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    ack_q.delete();
    rx_cnt = 0; acc_cnt = 0; model_out = 0; max_out = 0;
    done_cnt = 0; cyc_seen = 0; valid_seen = 0; last_cnt = 0;
    last_due = cyc_n;
  endtask

  task automatic start_run(input logic [31:0] b, input logic [31:0] e);
    clear_model();
    n_exp = (e > b) ? int'((e >> 2) - (b >> 2)) : 0;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(mem_rd({b[31:2], 2'b00} + 32'(4 * i)));
    next_adr = {b[31:2], 2'b00};
    @(posedge clk); #2;
    beg_a = b; end_a = e; start = 1'b1;
    start_cyc = cyc_n;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #3;
  endtask

  task automatic wait_words(input string tag, input int cnt);
    int k = 0;
    while (rx_cnt < cnt && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_words_reached"}, 32'(rx_cnt >= cnt), 32'd1);
  endtask

  task automatic end_checks(input string tag);
    check_val({tag, "_rx"}, rx_cnt, n_exp);
    check_val({tag, "_acc"}, acc_cnt, n_exp);
    check_val({tag, "_last"}, last_cnt, 32'(n_exp > 0));
    check_val({tag, "_done_once"}, done_cnt, 1);
    check_val({tag, "_idle"}, {29'd0, cyc, stb, busy}, 32'd0);
    check_val({tag, "_max_out"}, 32'(max_out <= 4), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; beg_a = '0; end_a = '0;
    #12;
    check_val("rst_ctrl", {26'd0, busy, done, cyc, stb, we, valid}, 32'd0);
    check_val("rst_adr", adr, 32'd0);
    check_val("rst_sel", {28'd0, sel}, 32'd0);
    check_val("rst_dat", wdo, 32'd0);
    check_val("rst_last", 32'(last), 32'd0);
    @(posedge clk); #2; rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic 4-word readout.
    start_run(32'h100, 32'h110);
    wait_done("basic", 200);
    end_checks("basic");

    // Empty region: done two cycles after start, no bus or stream activity.
    start_run(32'h200, 32'h200);
    wait_done("empty", 20);
    check_val("empty_done_lat", done_cyc - start_cyc, 2);
    check_val("empty_cyc", cyc_seen, 0);
    check_val("empty_valid", valid_seen, 0);
    end_checks("empty");

    // Backpressure: credit limits requests to the FIFO depth.
    ready_mode = 1;
    start_run(32'h1000, 32'h1040);
    repeat (30) @(posedge clk);
    #3;
    check_val("bp_acc_capped", acc_cnt, 4);
    check_val("bp_no_words", rx_cnt, 0);
    ready_mode = 0;
    wait_done("bp", 300);
    end_checks("bp");

    // Random stall, ack delay and sink readiness.
    stall_pct = 50; ack_max = 3; ready_mode = 2;
    start_run(32'h2000, 32'h2080);
    wait_done("rand", 3000);
    end_checks("rand");

    // Reset in the middle of a readout, then a fresh short region.
    stall_pct = 0; ack_max = 2; ready_mode = 0;
    start_run(32'h3000, 32'h3040);
    wait_words("rst", 5);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_ctrl", {27'd0, busy, done, cyc, stb, valid}, 32'd0);
    check_val("midrst_adr", adr, 32'd0);
    check_val("midrst_sel_last", {27'd0, sel, last}, 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    start_run(32'h300, 32'h308);
    wait_done("post_rst", 200);
    end_checks("post_rst");

    // start while busy must not disturb the running region.
    stall_pct = 30; ack_max = 3; ready_mode = 2;
    start_run(32'h4000, 32'h4020);
    wait_words("mid", 2);
    @(posedge clk); #2;
    beg_a = 32'h5000; end_a = 32'h5100; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("mid", 1000);
    end_checks("mid");
    repeat (5) @(posedge clk);
    check_val("mid_no_restart", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
